// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: radix-2 shift-add and restoring division, 34-cycle latency.
// Signed operation is compiled in only when MULT_DIV_SIGNED_EN is defined; otherwise is_signed is ignored.
module mult_div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        is_signed,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_div_done,
    output logic        busy,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        dbz_q, dbz_d;

    logic        signed_sel;
    logic        neg_a_in, neg_b_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic [32:0] mult_sum;
    logic [32:0] div_trial;
    logic [63:0] prod_raw, prod_fix;
    logic [31:0] quot_fix, rem_fix;

`ifdef MULT_DIV_SIGNED_EN
    assign signed_sel = is_signed;
`else
    assign signed_sel = 1'b0 & is_signed;
`endif

    // The accumulator pair holds {partial product, multiplier} or {remainder, shifting dividend/quotient}.
    always_comb begin
        neg_a_in  = signed_sel & op_a[31];
        neg_b_in  = signed_sel & op_b[31];
        a_mag_in  = neg_a_in ? (~op_a + 32'd1) : op_a;
        b_mag_in  = neg_b_in ? (~op_b + 32'd1) : op_b;
        mult_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_trial = {acc_hi_q, acc_lo_q[31]} - {1'b0, opnd_q};
        prod_raw  = {acc_hi_q, acc_lo_q};
        prod_fix  = (neg_a_q ^ neg_b_q) ? (~prod_raw + 64'd1) : prod_raw;
        quot_fix  = b_zero_q ? 32'hFFFF_FFFF
                  : ((neg_a_q ^ neg_b_q) ? (~acc_lo_q + 32'd1) : acc_lo_q);
        rem_fix   = neg_a_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (mult_start || div_start) begin
                    is_div_d = !mult_start;
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    b_zero_d = !mult_start && (op_b == 32'd0);
                    opnd_d   = mult_start ? a_mag_in : b_mag_in;
                    acc_lo_d = mult_start ? b_mag_in : a_mag_in;
                    acc_hi_d = 32'd0;
                    cnt_d    = 6'd0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_trial[32]) begin
                        acc_hi_d = div_trial[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = {acc_hi_q[30:0], acc_lo_q[31]};
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mult_sum[32:1];
                    acc_lo_d = {mult_sum[0], acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero remainder magnitude equals |op_a|, so the remainder sign rule restores op_a.
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == FIX);
        dbz_d  = (state_q == FIX) && b_zero_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dbz_q    <= dbz_d;
        end
    end

    assign hi            = hi_q;
    assign lo            = lo_q;
    assign mult_div_done = done_q;
    assign busy          = busy_q;
    assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus randomized operations against an arithmetic model.
module tb_mult_div_unit;

`ifdef MULT_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        is_signed = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_div_done;
    logic        busy;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_start = -1;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    mult_div_unit dut (
        .CLK(CLK),
        .RST(RST),
        .mult_start(mult_start),
        .div_start(div_start),
        .op_a(op_a),
        .op_b(op_b),
        .is_signed(is_signed),
        .hi(hi),
        .lo(lo),
        .mult_div_done(mult_div_done),
        .busy(busy),
        .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural operand values.
    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        exp_t        e;
        bit          s;
        logic [63:0] p;
        longint      sa, sb, q, r;
        s     = sgn && SIGNED_EN;
        e.dbz = 1'b0;
        if (is_mult) begin
            if (s) p = longint'($signed(a)) * longint'($signed(b));
            else   p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            q    = sa / sb;
            r    = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: checks done timing, busy window, result popping and output hold between completions.
    always @(negedge CLK) begin
        bit   exp_done;
        bit   exp_busy;
        exp_t e;
        if (RST) begin
            exp_done = (cur_start >= 0) && (cyc == cur_start + 33);
            exp_busy = (cur_start >= 0) && (cyc >= cur_start) && (cyc <= cur_start + 33);
            check_output("done_timing", {63'd0, mult_div_done}, {63'd0, exp_done});
            check_output("busy", {63'd0, busy}, {63'd0, exp_busy});
            if (mult_div_done) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("hi", {32'd0, hi}, {32'd0, e.hi});
                    check_output("lo", {32'd0, lo}, {32'd0, e.lo});
                    check_output("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else begin
                check_output("dbz_idle", {63'd0, div_by_zero}, 64'd0);
                check_output("hi_hold", {32'd0, hi}, {32'd0, last_hi});
                check_output("lo_hold", {32'd0, lo}, {32'd0, last_lo});
            end
        end
    end

    task automatic wait_idle();
        bit timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!busy && exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge CLK);
            #1;
        end
        check_output("idle_timeout", {63'd0, timed_out}, 64'd0);
    endtask

    task automatic apply_stimulus(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        wait_idle();
        @(posedge CLK);
        #1;
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        is_signed  = sgn;
        if (m || d) begin
            exp_q.push_back(model(m, a, b, sgn));
            cur_start = cyc + 1;
        end
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        is_signed  = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_hi"}, {32'd0, hi}, 64'd0);
        check_output({tag, "_lo"}, {32'd0, lo}, 64'd0);
        check_output({tag, "_done"}, {63'd0, mult_div_done}, 64'd0);
        check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_output({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 RST = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'd100, 32'd7, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h8765_4321, 32'd0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'd6, 32'd3, 1'b0);

        apply_stimulus(1'b1, 1'b0, 32'd1234, 32'd5678, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        mult_start = 1'b1;
        div_start  = 1'b1;
        op_a       = 32'd99;
        op_b       = 32'd0;
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        wait_idle();

        apply_stimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd13, 1'b0);
        repeat (19) @(posedge CLK);
        #1 RST = 1'b0;
        exp_q.delete();
        cur_start = -1;
        last_hi   = 32'd0;
        last_lo   = 32'd0;
        #1 check_reset_outputs("midop_reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        apply_stimulus(1'b1, 1'b0, 32'd5, 32'd5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            int          kind;
            a    = pick_operand();
            b    = pick_operand();
            kind = $urandom_range(0, 2);
            apply_stimulus(kind != 1, kind != 0, a, b, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        check_output("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; port names and polarity are as listed below.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 mult_start  input  1  single-cycle pulse; starts a multiply when sampled high in IDLE.
REQ-005 div_start  input  1  single-cycle pulse; starts a divide when sampled high in IDLE.
REQ-006 op_a  input  32  multiplicand or dividend (rs); sampled on the start edge only.
REQ-007 op_b  input  32  multiplier or divisor (rt); sampled on the start edge only.
REQ-008 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the start edge.
REQ-009 hi  output  32  multiply: product[63:32]; divide: remainder.
REQ-010 lo  output  32  multiply: product[31:0]; divide: quotient.
REQ-011 mult_div_done  output  1  one-cycle pulse; hi and lo are valid in that cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 div_by_zero  output  1  high together with mult_div_done when the completed divide had op_b == 0.

Function
REQ-014 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
- IDLE -> CALC when either start is sampled high.
- CALC -> FIX after 32 CALC cycles.
- FIX -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-015 On the start edge N, the block SHALL latch the operands, the operation and is_signed; it SHALL also clear the 6-bit iteration counter and enter CALC.
REQ-016 Each CALC cycle SHALL perform one iteration and increment the counter; on the edge where counter == 31, the FSM SHALL move to FIX (edge N+32).
REQ-017 Multiply SHALL be radix-2 shift-add on the operand magnitudes, producing a 64-bit unsigned product.
REQ-018 Divide SHALL be radix-2 restoring division on the operand magnitudes, producing a 32-bit quotient and a 32-bit remainder.
REQ-019 In signed mode, FIX SHALL apply sign correction:
- product negated if sign(op_a) XOR sign(op_b);
- quotient negated if sign(op_a) XOR sign(op_b);
- remainder takes the sign of op_a.
FIX SHALL then load hi and lo.
REQ-020 mult_div_done SHALL be high for exactly one cycle, in the DONE cycle between edges N+33 and N+34; total latency is 34 cycles from start to IDLE.
REQ-021 hi and lo SHALL change only on the FIX->DONE edge and hold their value until the next completion.
REQ-022 If mult_start and div_start are both high, multiply SHALL win; div_start is ignored.
REQ-023 A start asserted while busy = 1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-024 Divide with op_b == 0 SHALL run full latency and produce hi = op_a, lo = 32'hFFFFFFFF and div_by_zero = 1, with no sign correction.
REQ-025 Signed 32'h80000000 / 32'hFFFFFFFF SHALL produce lo = 32'h80000000, hi = 0 and div_by_zero = 0.
REQ-026 Operand inputs SHALL be don't-care in all cycles except the start edge.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, counter = 0, hi = 0, lo = 0, mult_div_done = 0, busy = 0 and div_by_zero = 0.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be handled normally.

Configuration
REQ-029 The macro MULT_DIV_SIGNED_EN SHALL control signed support.
- Defined: is_signed behaves as described in REQ-019.
- Undefined: is_signed is ignored, all operations are unsigned, the FIX state still exists with correction bypassed, and latency is unchanged.

Verification
REQ-030 Unsigned multiply: mult_start with 32'hFFFFFFFF x 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001, done high exactly 33 cycles after the start edge.
REQ-031 Signed multiply (MULT_DIV_SIGNED_EN defined): -3 x 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB.
REQ-032 Signed divide: -7 / 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF. Unsigned divide: 100 / 7 -> lo = 14, hi = 2.
REQ-033 Divide by zero: op_a = 32'h12345678, op_b = 0 -> hi = 32'h12345678, lo = 32'hFFFFFFFF, div_by_zero = 1 for one cycle.
REQ-034 Collisions: a new start at CALC cycle 10 -> ignored and the original result is unchanged; simultaneous mult_start and div_start with 6 and 3 -> lo = 18.
REQ-035 Reset: RST low at CALC cycle 20 -> all outputs 0 and no done pulse; a subsequent 5 x 5 -> lo = 25.
